// File: rtl/mem_bridge_pkg.sv
// Shared types for the data-side memory bridge: FSM states, address regions and the region decoder.
package mem_bridge_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [1:0] {REG_RAM, REG_OUT, REG_IN, REG_NONE} region_t;

    // Everything below base is RAM; the IO window holds outputs first, then inputs.
    function automatic region_t decode(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] n_out,
                                       input logic [31:0] n_in);
        if (addr < base)
            return REG_RAM;
        if ((addr - base) < n_out)
            return REG_OUT;
        if ((addr - base) < (n_out + n_in))
            return REG_IN;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/data_mem_bridge_sync_ram.sv
// Single-port RAM with a registered one-cycle read; read data holds until the next read.
module sync_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_bridge.sv
// Processor data-port bridge: RAM with configurable read/write latency plus an MMIO register window.
// Stalls via DataWaitreq; a request dropped while BUSY is abandoned without side effects.
module data_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                MEM_DEPTH = 4096,
    parameter int                RD_LAT    = 2,
    parameter int                WR_LAT    = 0,
    parameter int                NUM_OUT   = 4,
    parameter int                NUM_IN    = 2,
    parameter logic [ADDR_W-1:0] IO_BASE   = 16'hF000
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [ADDR_W-1:0]          DataAddr,
    input  logic [DATA_W-1:0]          DataOut,
    input  logic                       WriteData,
    input  logic                       ReadData,
    output logic [DATA_W-1:0]          DataIn,
    output logic                       DataWaitreq,
    output logic [NUM_OUT*DATA_W-1:0]  IoOut,
    input  logic [NUM_IN*DATA_W-1:0]   IoIn
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int MAX_L = (RD_LAT > WR_LAT) ? RD_LAT : ((WR_LAT > 1) ? WR_LAT : 1);
    localparam int CNT_W = $clog2(MAX_L + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    region_t           region_q;
    logic              src_ram;
    logic [DATA_W-1:0] io_rd_q;
    logic [DATA_W-1:0] io_out [NUM_OUT];

    logic              req;
    logic              is_wr;
    region_t           region;
    logic [ADDR_W-1:0] io_off;
    logic [CNT_W-1:0]  lat_cur;
    logic [DATA_W-1:0] io_rd_val;
    logic              ram_we;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign req    = ReadData | WriteData;
    assign is_wr  = WriteData;
    assign region = decode(32'(DataAddr), 32'(IO_BASE), 32'(NUM_OUT), 32'(NUM_IN));
    assign io_off = DataAddr - IO_BASE;

    always_comb begin
        lat_cur = '0;
        if (is_wr)
            lat_cur = (region == REG_RAM) ? CNT_W'(WR_LAT) : '0;
        else
            lat_cur = (region == REG_RAM) ? CNT_W'(RD_LAT) : CNT_W'(1);
    end

    // MMIO read value, captured at the acceptance edge; unmapped addresses read zero.
    always_comb begin
        io_rd_val = '0;
        for (int i = 0; i < NUM_OUT; i++)
            if (region == REG_OUT && io_off == ADDR_W'(i))
                io_rd_val = io_out[i];
        for (int j = 0; j < NUM_IN; j++)
            if (region == REG_IN && io_off == ADDR_W'(NUM_OUT + j))
                io_rd_val = IoIn[j*DATA_W +: DATA_W];
    end

    assign DataWaitreq = !Reset && req &&
                         ((state == IDLE && lat_cur != '0) || state == BUSY);

    // The RAM read is issued in the last stall cycle so its registered output lands on entry to DONE.
    assign ram_re = !Reset && req &&
                    ((state == IDLE && !is_wr && region == REG_RAM && RD_LAT == 1) ||
                     (state == BUSY && !wr_q && cnt == CNT_W'(1)));

    assign ram_we = !Reset &&
                    ((state == IDLE && req && is_wr && region == REG_RAM && WR_LAT == 0) ||
                     (state == DONE && wr_q && region_q == REG_RAM));

    assign ram_addr  = (state == IDLE) ? DataAddr[IDX_W-1:0] : addr_q;
    assign ram_wdata = (state == IDLE) ? DataOut : wdata_q;

    sync_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk   (Clock),
        .rst   (Reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            region_q <= REG_RAM;
            src_ram  <= 1'b0;
            io_rd_q  <= '0;
            for (int i = 0; i < NUM_OUT; i++)
                io_out[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q   <= DataAddr[IDX_W-1:0];
                        wdata_q  <= DataOut;
                        wr_q     <= is_wr;
                        region_q <= region;
                        if (lat_cur == '0) begin
                            for (int i = 0; i < NUM_OUT; i++)
                                if (region == REG_OUT && io_off == ADDR_W'(i))
                                    io_out[i] <= DataOut;
                        end else if (lat_cur == CNT_W'(1)) begin
                            state <= DONE;
                            if (!is_wr) begin
                                src_ram <= (region == REG_RAM);
                                if (region != REG_RAM)
                                    io_rd_q <= io_rd_val;
                            end
                        end else begin
                            state <= BUSY;
                            cnt   <= lat_cur - CNT_W'(1);
                        end
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                            if (!wr_q)
                                src_ram <= 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign DataIn = src_ram ? ram_rdata : io_rd_q;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_io_out
        assign IoOut[g*DATA_W +: DATA_W] = io_out[g];
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: two instances (RD_LAT=2/WR_LAT=0 and RD_LAT=1/WR_LAT=3) against a cycle-level transaction model.
module tb_data_mem_bridge;

    logic        clk;
    logic        rst     [2];
    logic [15:0] addr    [2];
    logic [15:0] dout    [2];
    logic        wr      [2];
    logic        rd      [2];
    logic [15:0] din     [2];
    logic        wait_s  [2];
    logic [63:0] io_out  [2];
    logic [31:0] io_in   [2];

    // Reference model state
    logic [15:0] mem      [2][4096];
    logic [15:0] m_io     [2][4];
    logic [15:0] exp_din  [2];
    logic        exp_wait [2];
    int          rd_lat   [2] = '{2, 1};
    int          wr_lat   [2] = '{0, 3};

    int n_checks = 0;
    int n_err    = 0;
    bit run      = 0;

    data_mem_bridge #(.RD_LAT(2), .WR_LAT(0)) dut0 (
        .Clock(clk), .Reset(rst[0]), .DataAddr(addr[0]), .DataOut(dout[0]),
        .WriteData(wr[0]), .ReadData(rd[0]), .DataIn(din[0]), .DataWaitreq(wait_s[0]),
        .IoOut(io_out[0]), .IoIn(io_in[0]));

    data_mem_bridge #(.RD_LAT(1), .WR_LAT(3)) dut1 (
        .Clock(clk), .Reset(rst[1]), .DataAddr(addr[1]), .DataOut(dout[1]),
        .WriteData(wr[1]), .ReadData(rd[1]), .DataIn(din[1]), .DataWaitreq(wait_s[1]),
        .IoOut(io_out[1]), .IoIn(io_in[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model_io(input int k);
        return {m_io[k][3], m_io[k][2], m_io[k][1], m_io[k][0]};
    endfunction

    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("waitreq%0d", k), 64'(wait_s[k]), 64'(exp_wait[k]));
                check($sformatf("datain%0d", k), 64'(din[k]), 64'(exp_din[k]));
                check($sformatf("ioout%0d", k), io_out[k], model_io(k));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        wr[k] = 1'b0;
        rd[k] = 1'b0;
        exp_wait[k] = 1'b0;
    endtask

    task automatic commit(input int k, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] off;
        off = a - 16'hF000;
        if (a < 16'hF000)
            mem[k][a[11:0]] = d;
        else if (off < 16'd4)
            m_io[k][off[1:0]] = d;
    endtask

    // One processor access starting at posedge+1; returns the number of stalled cycles seen.
    task automatic txn(input int k, input logic w, input logic r, input logic [15:0] a,
                       input logic [15:0] d, input int drop_at, output int stalls);
        int lat;
        logic [15:0] off;
        logic [15:0] rv;
        off = a - 16'hF000;
        if (a < 16'hF000) begin
            lat = w ? wr_lat[k] : rd_lat[k];
            rv  = mem[k][a[11:0]];
        end else begin
            lat = w ? 0 : 1;
            if (off < 16'd4)       rv = m_io[k][off[1:0]];
            else if (off == 16'd4) rv = io_in[k][15:0];
            else if (off == 16'd5) rv = io_in[k][31:16];
            else                   rv = 16'h0000;
        end
        addr[k] = a; dout[k] = d; wr[k] = w; rd[k] = r;
        exp_wait[k] = (lat > 0);
        stalls = 0;
        #1 stalls += int'(wait_s[k]);
        if (lat == 0) begin
            tick();
            commit(k, a, d);
            idle(k);
            return;
        end
        for (int c = 1; c < lat; c++) begin
            tick();
            if (c == drop_at) begin
                idle(k);
                tick();
                return;
            end
            addr[k] = 16'($urandom);
            dout[k] = 16'($urandom);
            #1 stalls += int'(wait_s[k]);
        end
        tick();
        idle(k);
        if (!w)
            exp_din[k] = rv;
        tick();
        if (w)
            commit(k, a, d);
    endtask

    initial begin
        int st;
        logic [15:0] a;
        logic [15:0] hold;
        int kind;
        int op;

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; addr[k] = '0; dout[k] = '0; wr[k] = 1'b0; rd[k] = 1'b0;
            io_in[k] = '0; exp_din[k] = '0; exp_wait[k] = 1'b0;
            for (int i = 0; i < 4; i++) m_io[k][i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_datain", 64'(din[k]), 64'h0);
            check("reset_ioout", io_out[k], 64'h0);
            check("reset_waitreq", 64'(wait_s[k]), 64'h0);
        end
        run = 1;
        tick();

        // Pre-fill a pool of RAM words so later reads never see uninitialised storage.
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                txn(k, 1'b1, 1'b0, 16'(i), 16'($urandom), 0, st);

        txn(0, 1'b1, 1'b0, 16'h0005, 16'h1234, 0, st);
        check("wr_ram_stall", 64'(st), 64'd0);
        txn(0, 1'b0, 1'b1, 16'h0005, 16'h0000, 0, st);
        check("rd_ram_stall", 64'(st), 64'd2);
        check("rd_ram_data", 64'(din[0]), 64'h1234);

        txn(0, 1'b1, 1'b0, 16'hF001, 16'h00AA, 0, st);
        check("io_wr_stall", 64'(st), 64'd0);
        hold = io_out[0][31:16];
        check("io_wr_data", 64'(hold), 64'h00AA);

        io_in[0] = 32'h0000_0305;
        tick();
        txn(0, 1'b0, 1'b1, 16'hF004, 16'h0000, 0, st);
        check("io_rd_stall", 64'(st), 64'd1);
        check("io_rd_data", 64'(din[0]), 64'h0305);

        txn(0, 1'b1, 1'b1, 16'h0007, 16'hBEEF, 0, st);
        check("both_datain", 64'(din[0]), 64'h0305);
        txn(0, 1'b0, 1'b1, 16'h0007, 16'h0000, 0, st);
        check("both_ram", 64'(din[0]), 64'hBEEF);

        txn(0, 1'b1, 1'b0, 16'h0009, 16'h9999, 0, st);
        txn(0, 1'b0, 1'b1, 16'h0009, 16'h0000, 1, st);
        #1;
        check("abort_waitreq", 64'(wait_s[0]), 64'h0);
        check("abort_datain", 64'(din[0]), 64'hBEEF);

        txn(0, 1'b1, 1'b0, 16'h1002, 16'h0042, 0, st);
        txn(0, 1'b0, 1'b1, 16'h0002, 16'h0000, 0, st);
        check("wrap_data", 64'(din[0]), 64'h0042);

        // Reset mid-write on the WR_LAT=3 instance must not commit anything.
        txn(1, 1'b1, 1'b0, 16'h0020, 16'h5A5A, 0, st);
        check("wr3_stall", 64'(st), 64'd3);
        txn(1, 1'b1, 1'b0, 16'hF002, 16'h7777, 0, st);
        addr[1] = 16'h0020; dout[1] = 16'hDEAD; wr[1] = 1'b1; exp_wait[1] = 1'b1;
        tick();
        rst[1] = 1'b1;
        exp_wait[1] = 1'b0;
        tick();
        rst[1] = 1'b0;
        idle(1);
        exp_din[1] = '0;
        for (int i = 0; i < 4; i++) m_io[1][i] = '0;
        check("rst_ioout", io_out[1], 64'h0);
        tick();
        txn(1, 1'b0, 1'b1, 16'h0020, 16'h0000, 0, st);
        check("rst_nocommit", 64'(din[1]), 64'h5A5A);
        check("rd1_stall", 64'(st), 64'd1);

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 150; n++) begin
                io_in[k] = $urandom;
                tick();
                kind = $urandom_range(0, 9);
                if (kind < 6)      a = {4'($urandom_range(0, 14)), 8'h00, 4'($urandom)};
                else if (kind < 8) a = 16'hF000 + 16'($urandom_range(0, 3));
                else if (kind < 9) a = 16'hF004 + 16'($urandom_range(0, 1));
                else               a = 16'hF006 + 16'($urandom_range(0, 16'h0FF9));
                op = $urandom_range(0, 2);
                txn(k, op != 1, op != 0, a, 16'($urandom),
                    ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0, st);
            end
        end

        tick();
        run = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
